div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/div_sched.sv
// div_sched: four-requester scheduler around one unsigned 32/24 restoring divider.
// One quotient bit is produced per cycle; a zero divisor short-circuits to a
// saturated quotient with div_by_zero set.
// Build option: DIV_SCHED_RR_EN selects round-robin arbitration; when it is
// undefined, fixed priority is used (requester 0 highest).
//
// state  | meaning
// S_IDLE | waiting for a request; req sampled only here
// S_CALC | shifting out quotient bits, cnt_q counts 31 down to 0
// S_DONE | one-cycle wrap-up before returning to IDLE
module div_sched (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] req_dividend,
  input  logic [95:0]  req_divisor,
  output logic [3:0]   grant,
  output logic [3:0]   done,
  output logic [31:0]  quotient,
  output logic         div_by_zero,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [23:0] dvs_q, dvs_d;
  logic [24:0] rem_q, rem_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  done_q, done_d;
  logic [31:0] quot_q, quot_d;
  logic        dbz_q, dbz_d;
  logic        busy_q, busy_d;

  logic [31:0] op_dvd [4];
  logic [23:0] op_dvs [4];
  logic [1:0]  pick;
  logic [25:0] trial;
  logic        q_bit;

`ifdef DIV_SCHED_RR_EN
  logic [1:0]  last_q, last_d;
  logic [1:0]  rr_idx;
  logic        rr_found;
`endif

  // Split the flat operand buses into per-requester views.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      op_dvd[k] = req_dividend[32*k +: 32];
      op_dvs[k] = req_divisor[24*k +: 24];
    end
  end

`ifdef DIV_SCHED_RR_EN
  // Round-robin pick: search upward starting just past the last grant.
  always_comb begin
    pick     = 2'd0;
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rr_idx = last_q + 2'(i) + 2'd1;
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        pick     = rr_idx;
      end
    end
  end
`else
  // Fixed-priority pick: lowest requester index wins.
  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        pick = 2'(i);
      end
    end
  end
`endif

  // One restoring step: the shifted 25-bit partial remainder minus the divisor;
  // the extra top bit of trial is the borrow.
  always_comb begin
    trial = {rem_q, dvd_q[31]} - {2'b00, dvs_q};
    q_bit = ~trial[25];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    grant_d = 4'b0000;
    done_d  = 4'b0000;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
`ifdef DIV_SCHED_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req != 4'b0000) begin
          sel_d   = pick;
          grant_d = 4'b0001 << pick;
          dvd_d   = op_dvd[pick];
          dvs_d   = op_dvs[pick];
          rem_d   = 25'd0;
          cnt_d   = 5'd31;
`ifdef DIV_SCHED_RR_EN
          last_d  = pick;
`endif
          state_d = (op_dvs[pick] == 24'd0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = q_bit ? trial[24:0] : {rem_q[23:0], dvd_q[31]};
        dvd_d = {dvd_q[30:0], q_bit};
        if (cnt_q == 5'd0) begin
          state_d = S_DONE;
          done_d  = 4'b0001 << sel_q;
          quot_d  = {dvd_q[30:0], q_bit};
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // A zero divisor skipped CALC, so its result is published on the way out.
        if (dvs_q == 24'd0) begin
          done_d = 4'b0001 << sel_q;
          quot_d = 32'hFFFF_FFFF;
          dbz_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 24'd0;
      rem_q   <= 25'd0;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      done_q  <= 4'b0000;
      quot_q  <= 32'd0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DIV_SCHED_RR_EN
      last_q  <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
`ifdef DIV_SCHED_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;

endmodule
